// File: rtl/comparator_arbiter_if.sv
// Client-side bus of the comparator arbiter: per-requester level requests with
// packed operands, and the shared one-cycle completion/result strobes.
interface comparator_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4
);
  // Handshake: a client raises req[k] with a/b slice k valid and keeps both
  // steady until it is granted; ack[k] is the one-cycle completion strobe and
  // less_than/equal_to/greater_than/error are valid only in that ack cycle.
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_in;
  logic [N_REQ*W-1:0] b_in;
  logic [N_REQ-1:0]   ack;
  logic               less_than;
  logic               equal_to;
  logic               greater_than;
  logic               error;
  logic               busy;

  modport master (
    output req, a_in, b_in,
    input  ack, less_than, equal_to, greater_than, error, busy
  );

  modport slave (
    input  req, a_in, b_in,
    output ack, less_than, equal_to, greater_than, error, busy
  );
endinterface

// File: rtl/comparator_arbiter.sv
// Round-robin sharing of one power-gated comparator: grant, reset pulse,
// enabled settle window, then a checked result returned with a one-cycle ack.
module comparator_arbiter #(
  parameter int N_REQ  = 4,
  parameter int W      = 4,
  parameter int SETTLE = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  comparator_arbiter_if.slave  bus,
  output logic [W-1:0]         cmp_a,
  output logic [W-1:0]         cmp_b,
  output logic                 cmp_enable,
  output logic                 cmp_reset,
  input  logic                 cmp_lt,
  input  logic                 cmp_eq,
  input  logic                 cmp_gt,
  output logic [1:0]           dbg_state
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, EVAL, RESP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    g_q, g_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     cmp_a_q, cmp_a_d;
  logic [W-1:0]     cmp_b_q, cmp_b_d;
  logic             cmp_enable_q, cmp_enable_d;
  logic             cmp_reset_q, cmp_reset_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [IW-1:0]    pick_idx;
  logic [2:0]       res;
  logic             res_one_hot;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!found && bus.req[idx]) begin
        found    = 1'b1;
        pick_idx = IW'(idx);
      end
    end
  end

  assign res         = {cmp_lt, cmp_eq, cmp_gt};
  assign res_one_hot = (res == 3'b100) || (res == 3'b010) || (res == 3'b001);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    g_d          = g_q;
    cnt_d        = cnt_q;
    cmp_a_d      = cmp_a_q;
    cmp_b_d      = cmp_b_q;
    cmp_enable_d = cmp_enable_q;
    cmp_reset_d  = cmp_reset_q;
    ack_d        = '0;
    lt_d         = lt_q;
    eq_d         = eq_q;
    gt_d         = gt_q;
    err_d        = 1'b0;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          g_d          = pick_idx;
          cmp_a_d      = bus.a_in[int'(pick_idx)*W +: W];
          cmp_b_d      = bus.b_in[int'(pick_idx)*W +: W];
          cmp_reset_d  = 1'b1;
          cmp_enable_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = CLEAR;
        end
      end
      CLEAR: begin
        cmp_reset_d  = 1'b0;
        cmp_enable_d = 1'b1;
        cnt_d        = CW'(SETTLE - 1);
        state_d      = EVAL;
      end
      EVAL: begin
        if (cnt_q == '0) begin
          // A result that is not exactly one-hot is reported as an error only.
          cmp_enable_d = 1'b0;
          ack_d[g_q]   = 1'b1;
          lt_d         = res_one_hot & cmp_lt;
          eq_d         = res_one_hot & cmp_eq;
          gt_d         = res_one_hot & cmp_gt;
          err_d        = ~res_one_hot;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        ptr_d   = (int'(g_q) == N_REQ - 1) ? '0 : g_q + IW'(1);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      g_q          <= '0;
      cnt_q        <= '0;
      cmp_a_q      <= '0;
      cmp_b_q      <= '0;
      cmp_enable_q <= 1'b0;
      cmp_reset_q  <= 1'b0;
      ack_q        <= '0;
      lt_q         <= 1'b0;
      eq_q         <= 1'b0;
      gt_q         <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      g_q          <= g_d;
      cnt_q        <= cnt_d;
      cmp_a_q      <= cmp_a_d;
      cmp_b_q      <= cmp_b_d;
      cmp_enable_q <= cmp_enable_d;
      cmp_reset_q  <= cmp_reset_d;
      ack_q        <= ack_d;
      lt_q         <= lt_d;
      eq_q         <= eq_d;
      gt_q         <= gt_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.less_than    = lt_q;
  assign bus.equal_to     = eq_q;
  assign bus.greater_than = gt_q;
  assign bus.error        = err_q;
  assign bus.busy         = busy_q;
  assign cmp_a            = cmp_a_q;
  assign cmp_b            = cmp_b_q;
  assign cmp_enable       = cmp_enable_q;
  assign cmp_reset        = cmp_reset_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_comparator_arbiter.sv
// Bench for comparator_arbiter: directed scenarios plus randomized operations,
// checked against a round-robin / arithmetic reference model.
module tb_comparator_arbiter;
  localparam int N_REQ  = 4;
  localparam int W      = 4;
  localparam int SETTLE = 3;
  localparam int LAT    = SETTLE + 2;
  localparam int GAP    = SETTLE + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  comparator_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

  logic [W-1:0] cmp_a, cmp_b;
  logic         cmp_enable, cmp_reset;
  logic         cmp_lt, cmp_eq, cmp_gt;
  logic [1:0]   dbg_state;
  int           fault;

  comparator_arbiter #(.N_REQ(N_REQ), .W(W), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_enable (cmp_enable),
    .cmp_reset  (cmp_reset),
    .cmp_lt     (cmp_lt),
    .cmp_eq     (cmp_eq),
    .cmp_gt     (cmp_gt),
    .dbg_state  (dbg_state)
  );

  // External comparator: answers only while powered; fault 1 = lt&gt, 2 = none.
  always_comb begin
    cmp_lt = 1'b0;
    cmp_eq = 1'b0;
    cmp_gt = 1'b0;
    if (cmp_enable) begin
      case (fault)
        0: begin
          cmp_lt = (cmp_a < cmp_b);
          cmp_eq = (cmp_a == cmp_b);
          cmp_gt = (cmp_a > cmp_b);
        end
        1: begin
          cmp_lt = 1'b1;
          cmp_gt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int               checks   = 0;
  int               failures = 0;
  int               m_ptr    = 0;
  logic [N_REQ-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_REQ-1:0] onehot(input int k);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  // {error, lt, eq, gt} from the operands and the comparator's health.
  function automatic logic [3:0] exp_res(input logic [W-1:0] a, input logic [W-1:0] b, input int flt);
    if (flt != 0) return 4'b1000;
    if (a < b)    return 4'b0100;
    if (a == b)   return 4'b0010;
    return 4'b0001;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic rand_operands();
    for (int j = 0; j < N_REQ; j++) begin
      bus.a_in[j*W +: W] = W'($urandom_range(0, (1 << W) - 1));
      bus.b_in[j*W +: W] = W'($urandom_range(0, (1 << W) - 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},  32'(bus.ack), 0);
    check({tag, "_lt"},   32'(bus.less_than), 0);
    check({tag, "_eq"},   32'(bus.equal_to), 0);
    check({tag, "_gt"},   32'(bus.greater_than), 0);
    check({tag, "_err"},  32'(bus.error), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_en"},   32'(cmp_enable), 0);
    check({tag, "_rst"},  32'(cmp_reset), 0);
    check({tag, "_a"},    32'(cmp_a), 0);
    check({tag, "_b"},    32'(cmp_b), 0);
  endtask

  // One isolated operation on requester k; hold=0 drops req during CLEAR.
  task automatic run_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int flt, input bit hold);
    logic [3:0] r;
    r = exp_res(a, b, flt);
    @(negedge clk);
    fault = flt;
    rand_operands();
    bus.a_in[k*W +: W] = a;
    bus.b_in[k*W +: W] = b;
    bus.req            = onehot(k);
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      if (c <= LAT) begin
        check("op_busy",      32'(bus.busy), 1);
        check("op_cmp_reset", 32'(cmp_reset), 32'(c == 1));
        check("op_cmp_en",    32'(cmp_enable), 32'(c >= 2 && c <= SETTLE + 1));
        check("op_cmp_a",     32'(cmp_a), 32'(a));
        check("op_cmp_b",     32'(cmp_b), 32'(b));
        check("op_ack",       32'(bus.ack), (c == LAT) ? 32'(onehot(k)) : 0);
      end else begin
        check("op_busy_after", 32'(bus.busy), 0);
        check("op_ack_after",  32'(bus.ack), 0);
        check("op_err_after",  32'(bus.error), 0);
      end
      if (c == LAT) begin
        check("op_err", 32'(bus.error), 32'(r[3]));
        check("op_lt",  32'(bus.less_than), 32'(r[2]));
        check("op_eq",  32'(bus.equal_to), 32'(r[1]));
        check("op_gt",  32'(bus.greater_than), 32'(r[0]));
        bus.req = '0;
        m_ptr   = (k + 1) % N_REQ;
      end
      if (c == 1 && !hold) bus.req = '0;
      if (c == 3) rand_operands();
    end
    fault = 0;
  endtask

  // Mask held until n_ops acks; grants must follow round-robin from m_ptr.
  task automatic run_contention(input logic [N_REQ-1:0] mask, input int n_ops);
    int p, cyc, done, next_ack, gi;
    logic [N_REQ*W-1:0] av, bv;
    logic [N_REQ-1:0]   e;
    logic [3:0]         r;
    p = m_ptr;
    exp_q.delete();
    for (int n = 0; n < n_ops; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        int idx;
        idx = (p + i) % N_REQ;
        if (mask[idx]) begin
          exp_q.push_back(onehot(idx));
          p = (idx + 1) % N_REQ;
          break;
        end
      end
    end
    @(negedge clk);
    fault = 0;
    rand_operands();
    av       = bus.a_in;
    bv       = bus.b_in;
    bus.req  = mask;
    cyc      = 0;
    done     = 0;
    next_ack = LAT;
    while (done < n_ops && cyc < LAT + n_ops * GAP + 4) begin
      @(negedge clk);
      cyc++;
      if (cyc == next_ack) begin
        e  = exp_q.pop_front();
        gi = idx_of(e);
        r  = exp_res(av[gi*W +: W], bv[gi*W +: W], 0);
        check("rr_ack", 32'(bus.ack), 32'(e));
        check("rr_lt",  32'(bus.less_than), 32'(r[2]));
        check("rr_eq",  32'(bus.equal_to), 32'(r[1]));
        check("rr_gt",  32'(bus.greater_than), 32'(r[0]));
        check("rr_err", 32'(bus.error), 0);
        m_ptr    = (gi + 1) % N_REQ;
        done++;
        next_ack += GAP;
        if (done == n_ops) bus.req = '0;
      end else begin
        check("rr_no_ack", 32'(bus.ack), 0);
      end
    end
    if (done < n_ops) check("rr_timeout", 32'(done), 32'(n_ops));
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset    = 1'b1;
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    fault    = 0;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;

    // all four requesting straight out of reset: 0,1,2,3,0,1
    run_contention(4'b1111, 6);

    run_op(0, 4'd5, 4'd9, 0, 1'b1);
    run_op(2, 4'hA, 4'hA, 0, 1'b1);
    run_op(1, 4'hF, 4'h0, 0, 1'b1);

    // pointer wrap: after 3, both 3 and 0 request -> 0 first
    run_op(3, 4'd2, 4'd7, 0, 1'b1);
    run_contention(4'b1001, 2);

    // faulty comparator, then recovery
    run_op(2, 4'd3, 4'd3, 1, 1'b1);
    run_op(0, 4'd8, 4'd1, 2, 1'b1);
    run_op(3, 4'd8, 4'd1, 0, 1'b1);

    // abort during the second EVAL cycle
    @(negedge clk);
    rand_operands();
    bus.req = 4'b0100;
    repeat (3) @(negedge clk);
    check("abort_pre_en", 32'(cmp_enable), 1);
    reset   = 1'b1;
    bus.req = '0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
    for (int c = 0; c < 2 * GAP; c++) begin
      @(negedge clk);
      check("abort_no_ack",  32'(bus.ack), 0);
      check("abort_no_busy", 32'(bus.busy), 0);
    end
    run_op(1, 4'd6, 4'd4, 0, 1'b1);

    // req dropped in CLEAR still completes
    run_op(1, 4'd1, 4'd12, 0, 1'b0);

    // randomized mix
    for (int n = 0; n < 30; n++) begin
      int flt;
      flt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_op(int'($urandom_range(0, N_REQ - 1)),
             W'($urandom_range(0, (1 << W) - 1)),
             W'($urandom_range(0, (1 << W) - 1)),
             flt, 1'($urandom_range(0, 1)));
      if ((n % 5) == 4)
        run_contention(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)),
                       int'($urandom_range(1, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
